quadrature_decoder: RTL and testbench

//  Front end for the up/down counter. Converts a 2-phase quadrature encoder input (A/B) into

---
 rtl/quad_pkg.sv | 24 ++
 rtl/quad_input_filter.sv | 71 +++++++
 rtl/quadrature_decoder.sv | 87 ++++++++
 tb/tb_quadrature_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// quad_pkg - quadrature state encodings, direction constants and up-sequence helper.
package quad_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Successor of an {A,B} state when the encoder turns in the up direction.
  function automatic logic [1:0] quad_next_up(input logic [1:0] state);
    logic [1:0] nxt;
    case (state)
      Q00:     nxt = Q10;
      Q10:     nxt = Q11;
      Q11:     nxt = Q01;
      default: nxt = Q00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// quad_input_filter - 2-flop synchroniser plus stability counter producing an accept strobe.
module quad_input_filter #(
  parameter int FILTER = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] pins,
  input  logic       primed,
  output logic [1:0] state,
  output logic [1:0] new_val,
  output logic       accept
);

  localparam int CW = (FILTER < 1) ? 1 : $clog2(FILTER + 1);
  localparam logic [CW-1:0] FMAX = CW'(FILTER);

  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    cand_q, cand_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    warm_q, warm_d;
  logic          hold_q, hold_d;
  logic [CW-1:0] run;
  logic          warm;

  always_comb begin
    sync1_d = pins;
    sync2_d = sync1_q;
    cand_d  = sync2_q;
    warm    = (warm_q == 2'd2);
    warm_d  = warm ? warm_q : warm_q + 2'd1;
    if (sync2_q != cand_q) begin
      run = CW'(1);
    end else if (cnt_q == FMAX) begin
      run = cnt_q;
    end else begin
      run = cnt_q + CW'(1);
    end
    // Until primed, the first stable level is accepted even if it equals the reset state.
    accept  = warm && !hold_q && (run == FMAX) && ((sync2_q != state_q) || !primed);
    // The cycle after an accept does not count, keeping accepts at least FILTER+1 apart.
    cnt_d   = (warm && !hold_q && !accept) ? run : '0;
    hold_d  = accept;
    state_d = accept ? sync2_q : state_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      state_q <= '0;
      cnt_q   <= '0;
      warm_q  <= '0;
      hold_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      hold_q  <= hold_d;
    end
  end

  assign state   = state_q;
  assign new_val = sync2_q;

endmodule

// File: rtl/quadrature_decoder.sv
// quadrature_decoder - A/B quadrature to step/dir pulses with wrapping position and sticky error.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int FILTER = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [WIDTH-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             err
);

  logic [WIDTH-1:0] pos_q, pos_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             primed_q, primed_d;
  logic [1:0]       old_state;
  logic [1:0]       new_state;
  logic             accept;

  quad_input_filter #(.FILTER(FILTER)) u_filter (
    .clk     (clk),
    .reset   (reset),
    .pins    ({enc_a, enc_b}),
    .primed  (primed_q),
    .state   (old_state),
    .new_val (new_state),
    .accept  (accept)
  );

  always_comb begin
    pos_d    = pos_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    err_d    = err_q;
    primed_d = primed_q;
    if (accept) begin
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if ((old_state ^ new_state) == 2'b11) begin
        err_d = 1'b1;
      end else if (quad_next_up(old_state) == new_state) begin
        pos_d  = pos_q + WIDTH'(1);
        dir_d  = DIR_UP;
        step_d = 1'b1;
      end else begin
        pos_d  = pos_q - WIDTH'(1);
        dir_d  = DIR_DOWN;
        step_d = 1'b1;
      end
    end
    if (clear) begin
      pos_d  = '0;
      err_d  = 1'b0;
      step_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      primed_q <= primed_d;
    end
  end

  assign pos  = pos_q;
  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder - directed vector table plus corner-case sequences for quadrature_decoder.
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] pos;
  logic       step;
  logic       dir;
  logic       err;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int consec = 0;
  logic step_prev = 1'b0;

  quadrature_decoder #(.WIDTH(4), .FILTER(2)) dut (
    .clk   (clk),
    .reset (reset),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .clear (clear),
    .pos   (pos),
    .step  (step),
    .dir   (dir),
    .err   (err)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    if (step === 1'b1) step_cnt++;
    if (step === 1'b1 && step_prev === 1'b1) consec++;
    step_prev = step;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] pins;
    logic       clr;
    int         hold;
    logic [3:0] pos;
    logic       dir;
    logic       err;
    int         steps;
  } vec_t;

  vec_t tbl[11];
  logic [1:0] up_seq[7];

  initial begin
    int s0;
    tbl[0]  = '{2'b10, 1'b0, 10, 4'd1,  1'b1, 1'b0, 1};
    tbl[1]  = '{2'b11, 1'b0, 10, 4'd2,  1'b1, 1'b0, 1};
    tbl[2]  = '{2'b01, 1'b0, 10, 4'd3,  1'b1, 1'b0, 1};
    tbl[3]  = '{2'b00, 1'b0, 10, 4'd4,  1'b1, 1'b0, 1};
    tbl[4]  = '{2'b00, 1'b1, 10, 4'd0,  1'b1, 1'b0, 0};
    tbl[5]  = '{2'b01, 1'b0, 10, 4'd15, 1'b0, 1'b0, 1};
    tbl[6]  = '{2'b00, 1'b0, 10, 4'd0,  1'b1, 1'b0, 1};
    tbl[7]  = '{2'b11, 1'b0, 10, 4'd0,  1'b1, 1'b1, 0};
    tbl[8]  = '{2'b11, 1'b1, 10, 4'd0,  1'b1, 1'b0, 0};
    tbl[9]  = '{2'b01, 1'b0, 10, 4'd1,  1'b1, 1'b0, 1};
    tbl[10] = '{2'b11, 1'b0, 10, 4'd0,  1'b0, 1'b0, 1};
    up_seq[0] = 2'b01; up_seq[1] = 2'b00; up_seq[2] = 2'b10; up_seq[3] = 2'b11;
    up_seq[4] = 2'b01; up_seq[5] = 2'b00; up_seq[6] = 2'b10;

    // Reset state, then release and let the first stable level prime the decoder.
    @(negedge clk);
    chk("reset_pos", pos, 0);
    chk("reset_step", step, 0);
    chk("reset_dir", dir, 0);
    chk("reset_err", err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("prime_pos", pos, 0);
    chk("prime_steps", step_cnt, 0);
    chk("prime_err", err, 0);

    for (int i = 0; i < 11; i++) begin
      s0 = step_cnt;
      {enc_a, enc_b} = tbl[i].pins;
      clear = tbl[i].clr;
      @(negedge clk);
      clear = 1'b0;
      repeat (tbl[i].hold - 1) @(negedge clk);
      chk($sformatf("vec%0d_pos", i), pos, tbl[i].pos);
      chk($sformatf("vec%0d_dir", i), dir, tbl[i].dir);
      chk($sformatf("vec%0d_err", i), err, tbl[i].err);
      chk($sformatf("vec%0d_steps", i), step_cnt - s0, tbl[i].steps);
    end

    // One-cycle glitch on A is rejected; a two-cycle glitch is a real step and back.
    s0 = step_cnt;
    enc_a = 1'b0;
    @(negedge clk);
    enc_a = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch1_steps", step_cnt - s0, 0);
    chk("glitch1_pos", pos, 0);
    chk("glitch1_dir", dir, 0);
    s0 = step_cnt;
    enc_a = 1'b0;
    repeat (2) @(negedge clk);
    enc_a = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch2_steps", step_cnt - s0, 2);
    chk("glitch2_pos", pos, 0);
    chk("glitch2_err", err, 0);

    // Walk up to pos 7, then reset mid-operation with pins at 11.
    for (int i = 0; i < 7; i++) begin
      {enc_a, enc_b} = up_seq[i];
      repeat (6) @(negedge clk);
    end
    chk("walk_pos", pos, 7);
    chk("walk_dir", dir, 1);
    reset = 1'b0;
    {enc_a, enc_b} = 2'b11;
    #1;
    chk("async_rst_pos", pos, 0);
    chk("async_rst_dir", dir, 0);
    chk("async_rst_step", step, 0);
    chk("async_rst_err", err, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    s0 = step_cnt;
    repeat (10) @(negedge clk);
    chk("reprime_steps", step_cnt - s0, 0);
    chk("reprime_pos", pos, 0);
    chk("reprime_err", err, 0);
    {enc_a, enc_b} = 2'b01;
    repeat (10) @(negedge clk);
    chk("after_rst_pos", pos, 1);
    chk("after_rst_dir", dir, 1);
    chk("after_rst_err", err, 0);

    // Latency: A rises just before edge 0; step appears after edge 3 only.
    enc_a = 1'b1;
    @(negedge clk);
    chk("lat_e0_step", step, 0);
    @(negedge clk);
    chk("lat_e1_step", step, 0);
    @(negedge clk);
    chk("lat_e2_step", step, 0);
    @(negedge clk);
    chk("lat_e3_step", step, 1);
    chk("lat_e3_pos", pos, 0);
    chk("lat_e3_dir", dir, 0);
    @(negedge clk);
    chk("lat_e4_step", step, 0);
    repeat (6) @(negedge clk);

    // Clear on the accept edge wins; the accepted state still advances.
    enc_a = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_acc_step", step, 0);
    chk("clr_acc_pos", pos, 0);
    repeat (6) @(negedge clk);
    {enc_a, enc_b} = 2'b00;
    repeat (10) @(negedge clk);
    chk("post_clr_pos", pos, 1);
    chk("post_clr_dir", dir, 1);
    chk("post_clr_err", err, 0);
    chk("no_consec_step", consec, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
